dfi_upd_lp_arbiter: RTL and testbench

Controller-side sequencer for the DFI update, PHY-master and low-power handshake groups. It sits between the memory-controller command scheduler and the DFI boundary and grants exactly one handshake at a time (phyupd, phymstr, ctrlupd, lp). Before any grant it drains command/read/write traffic, which keeps the DFI forbidden-state and idle-bus rules true by construction.

---
 rtl/dfi_upd_lp_arbiter_pkg.sv | 41 ++++
 rtl/dfi_upd_lp_arbiter_if.sv | 38 +++
 rtl/dfi_upd_lp_arbiter_timer.sv | 37 +++
 rtl/dfi_upd_lp_arbiter.sv | 178 +++++++++++++++++
 tb/tb_dfi_upd_lp_arbiter.sv | 381 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dfi_upd_lp_arbiter_pkg.sv
// Shared types and default timing for the DFI update / low-power arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dfi_arb_pkg;

  // Default timing, kept identical to the DFI agent defines.
  localparam int TLP_RESP_DEF     = 8;
  localparam int TCTRLUPD_MIN_DEF = 4;
  localparam int TCTRLUPD_MAX_DEF = 32;
  localparam int WAKEUP_W         = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_PHYUPD,
    ST_PHYMSTR,
    ST_CTRLUPD,
    ST_LP_WAIT,
    ST_LP_ACTIVE,
    ST_LP_EXIT
  } arb_state_e;

  // One-hot record of which handshake owns the DFI boundary.
  typedef struct packed {
    logic lp;
    logic ctrlupd;
    logic phymstr;
    logic phyupd;
  } grant_t;

  // State entered once the drain completes for a given grant.
  function automatic arb_state_e grant_target(grant_t g);
    arb_state_e s;
    if (g.phyupd)       s = ST_PHYUPD;
    else if (g.phymstr) s = ST_PHYMSTR;
    else if (g.ctrlupd) s = ST_CTRLUPD;
    else                s = ST_LP_WAIT;
    return s;
  endfunction

endpackage

// File: rtl/dfi_upd_lp_arbiter_if.sv
// DFI update, PHY-master and low-power handshake bundle.
// Latency: n/a (wires only).
// Backpressure: req/ack handshakes; the PHY side paces every transfer.
interface dfi_upd_lp_if;
  import dfi_arb_pkg::*;

  logic                ctrlupd_req;
  logic                ctrlupd_ack;
  logic                phyupd_req;
  logic                phyupd_ack;
  logic                phymstr_req;
  logic                phymstr_ack;
  logic                lp_ctrl_req;
  logic [WAKEUP_W-1:0] lp_ctrl_wakeup;
  logic                lp_ctrl_ack;
  logic                lp_data_req;
  logic [WAKEUP_W-1:0] lp_data_wakeup;
  logic                lp_data_ack;

  // Controller side.
  modport master (
    output ctrlupd_req, input  ctrlupd_ack,
    input  phyupd_req,  output phyupd_ack,
    input  phymstr_req, output phymstr_ack,
    output lp_ctrl_req, output lp_ctrl_wakeup, input lp_ctrl_ack,
    output lp_data_req, output lp_data_wakeup, input lp_data_ack
  );

  // PHY side.
  modport slave (
    input  ctrlupd_req, output ctrlupd_ack,
    output phyupd_req,  input  phyupd_ack,
    output phymstr_req, input  phymstr_ack,
    input  lp_ctrl_req, input  lp_ctrl_wakeup, output lp_ctrl_ack,
    input  lp_data_req, input  lp_data_wakeup, output lp_data_ack
  );

endinterface

// File: rtl/dfi_upd_lp_arbiter_timer.sv
// Saturating up-counter with clear, load and compare-equal.
// Latency: count updates one cycle after clear/load/inc; eq is a decode of count.
// Backpressure: none; saturates at all-ones instead of wrapping.
module dfi_arb_timer #(
  parameter int W = 6
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic [W-1:0] cmp_val,
  output logic [W-1:0] count,
  output logic         eq
);

  logic [W-1:0] count_d, count_q;

  // Next count: clear beats load beats increment; hold at all-ones.
  always_comb begin
    count_d = count_q;
    if (clear)                       count_d = '0;
    else if (load)                   count_d = load_val;
    else if (inc && (count_q != '1)) count_d = count_q + W'(1);
  end

  // Count register.
  always_ff @(posedge clock) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;
  assign eq    = (count_q == cmp_val);

endmodule

// File: rtl/dfi_upd_lp_arbiter.sv
// Grants one DFI handshake (phyupd, phymstr, ctrlupd, lp) at a time after draining traffic.
// Latency: request sampled -> DRAIN next cycle -> handshake one cycle after traffic_idle.
// Backpressure: hold_traffic stalls the scheduler in every non-IDLE state.
module dfi_upd_lp_arbiter
  import dfi_arb_pkg::*;
#(
  parameter int TLP_RESP     = TLP_RESP_DEF,
  parameter int TCTRLUPD_MIN = TCTRLUPD_MIN_DEF,
  parameter int TCTRLUPD_MAX = TCTRLUPD_MAX_DEF,
  parameter int CNT_W        = $clog2(TCTRLUPD_MAX + 1)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                init_start,
  input  logic                traffic_idle,
  output logic                hold_traffic,
  input  logic                mc_ctrlupd_start,
  input  logic                mc_lp_en,
  input  logic                mc_lp_data_only,
  input  logic [WAKEUP_W-1:0] mc_lp_wakeup,
  output logic                lp_denied,
  output logic                ctrlupd_done,
  dfi_upd_lp_if.master        dfi
);

  arb_state_e          state_d, state_q;
  grant_t              grant_d, grant_q;
  logic                pending_d, pending_q;
  logic                data_only_d, data_only_q;
  logic [WAKEUP_W-1:0] wakeup_d, wakeup_q;

  logic                hold_d, hold_q;
  logic                phyupd_ack_d, phyupd_ack_q;
  logic                phymstr_ack_d, phymstr_ack_q;
  logic                ctrlupd_req_d, ctrlupd_req_q;
  logic                lp_ctrl_req_d, lp_ctrl_req_q;
  logic                lp_data_req_d, lp_data_req_q;
  logic [WAKEUP_W-1:0] lp_ctrl_wk_d, lp_ctrl_wk_q;
  logic [WAKEUP_W-1:0] lp_data_wk_d, lp_data_wk_q;
  logic                lp_denied_d, lp_denied_q;
  logic                ctrlupd_done_d, ctrlupd_done_q;

  logic [CNT_W-1:0]    cnt, cmp_val;
  logic                cnt_eq, lp_acked;

  // The counter restarts on every state change; one compare serves both timeouts.
  assign cmp_val = (state_q == ST_LP_WAIT) ? CNT_W'(TLP_RESP - 1) : CNT_W'(TCTRLUPD_MAX - 1);

  dfi_arb_timer #(.W(CNT_W)) u_timer (
    .clock    (clock),
    .reset    (reset),
    .clear    (state_d != state_q),
    .load     (1'b0),
    .load_val ('0),
    .inc      (1'b1),
    .cmp_val  (cmp_val),
    .count    (cnt),
    .eq       (cnt_eq)
  );

  assign lp_acked = dfi.lp_data_ack && (data_only_q || dfi.lp_ctrl_ack);

  // Next state plus registered-output decode; count holds cycles-in-state minus one.
  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    data_only_d    = data_only_q;
    wakeup_d       = wakeup_q;
    lp_denied_d    = 1'b0;
    ctrlupd_done_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        grant_d = '0;
        if (!init_start) begin
          if (dfi.phyupd_req)                         grant_d.phyupd  = 1'b1;
          else if (dfi.phymstr_req)                   grant_d.phymstr = 1'b1;
          else if (pending_q || mc_ctrlupd_start)     grant_d.ctrlupd = 1'b1;
          else if (mc_lp_en) begin
            grant_d.lp  = 1'b1;
            data_only_d = mc_lp_data_only;
            wakeup_d    = mc_lp_wakeup;
          end
          if (grant_d != '0) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // A PHY update must not wait behind controller-initiated work.
        if ((grant_q.ctrlupd || grant_q.lp) && dfi.phyupd_req) begin
          grant_d        = '0;
          grant_d.phyupd = 1'b1;
        end
        if (grant_d.lp && !mc_lp_en)          state_d = ST_IDLE;
        else if (traffic_idle && !init_start) state_d = grant_target(grant_d);
      end
      ST_PHYUPD:  if (!dfi.phyupd_req)  state_d = ST_IDLE;
      ST_PHYMSTR: if (!dfi.phymstr_req) state_d = ST_IDLE;
      ST_CTRLUPD: begin
        if (((cnt >= CNT_W'(TCTRLUPD_MIN - 1)) && !dfi.ctrlupd_ack) || cnt_eq) begin
          state_d        = ST_IDLE;
          ctrlupd_done_d = 1'b1;
        end
      end
      ST_LP_WAIT: begin
        if (!mc_lp_en)     state_d = ST_LP_EXIT;
        else if (lp_acked) state_d = ST_LP_ACTIVE;
        else if (cnt_eq) begin
          state_d     = ST_IDLE;
          lp_denied_d = 1'b1;
        end
      end
      ST_LP_ACTIVE: if (!mc_lp_en) state_d = ST_LP_EXIT;
      ST_LP_EXIT:   if (!dfi.lp_ctrl_ack && !dfi.lp_data_ack) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase

    // Start pulses merge into one pending update until it completes.
    pending_d = (pending_q || mc_ctrlupd_start) && !ctrlupd_done_d;

    hold_d        = (state_d != ST_IDLE);
    phyupd_ack_d  = (state_d == ST_PHYUPD);
    phymstr_ack_d = (state_d == ST_PHYMSTR);
    ctrlupd_req_d = (state_d == ST_CTRLUPD);
    lp_data_req_d = (state_d == ST_LP_WAIT) || (state_d == ST_LP_ACTIVE);
    lp_ctrl_req_d = lp_data_req_d && !data_only_d;
    lp_data_wk_d  = lp_data_req_d ? wakeup_d : '0;
    lp_ctrl_wk_d  = lp_ctrl_req_d ? wakeup_d : '0;
  end

  // State, context and output registers; reset drops every handshake at once.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      grant_q        <= '0;
      pending_q      <= 1'b0;
      data_only_q    <= 1'b0;
      wakeup_q       <= '0;
      hold_q         <= 1'b0;
      phyupd_ack_q   <= 1'b0;
      phymstr_ack_q  <= 1'b0;
      ctrlupd_req_q  <= 1'b0;
      lp_ctrl_req_q  <= 1'b0;
      lp_data_req_q  <= 1'b0;
      lp_ctrl_wk_q   <= '0;
      lp_data_wk_q   <= '0;
      lp_denied_q    <= 1'b0;
      ctrlupd_done_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      pending_q      <= pending_d;
      data_only_q    <= data_only_d;
      wakeup_q       <= wakeup_d;
      hold_q         <= hold_d;
      phyupd_ack_q   <= phyupd_ack_d;
      phymstr_ack_q  <= phymstr_ack_d;
      ctrlupd_req_q  <= ctrlupd_req_d;
      lp_ctrl_req_q  <= lp_ctrl_req_d;
      lp_data_req_q  <= lp_data_req_d;
      lp_ctrl_wk_q   <= lp_ctrl_wk_d;
      lp_data_wk_q   <= lp_data_wk_d;
      lp_denied_q    <= lp_denied_d;
      ctrlupd_done_q <= ctrlupd_done_d;
    end
  end

  assign hold_traffic       = hold_q;
  assign lp_denied          = lp_denied_q;
  assign ctrlupd_done       = ctrlupd_done_q;
  assign dfi.phyupd_ack     = phyupd_ack_q;
  assign dfi.phymstr_ack    = phymstr_ack_q;
  assign dfi.ctrlupd_req    = ctrlupd_req_q;
  assign dfi.lp_ctrl_req    = lp_ctrl_req_q;
  assign dfi.lp_data_req    = lp_data_req_q;
  assign dfi.lp_ctrl_wakeup = lp_ctrl_wk_q;
  assign dfi.lp_data_wakeup = lp_data_wk_q;

endmodule

// File: tb/tb_dfi_upd_lp_arbiter.sv
// Bench for dfi_upd_lp_arbiter: scenario tasks with a length scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_dfi_upd_lp_arbiter;

  localparam int TLP    = 8;
  localparam int TC_MIN = 4;
  localparam int TC_MAX = 32;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       init_start = 1'b0;
  logic       traffic_idle = 1'b1;
  logic       hold_traffic;
  logic       mc_ctrlupd_start = 1'b0;
  logic       mc_lp_en = 1'b0;
  logic       mc_lp_data_only = 1'b0;
  logic [5:0] mc_lp_wakeup = '0;
  logic       lp_denied;
  logic       ctrlupd_done;

  int passed = 0;
  int total = 0;
  int excl_viol = 0;
  int exp_q[$];

  always #5 clock = ~clock;

  dfi_upd_lp_if dfi();

  dfi_upd_lp_arbiter dut (
    .clock            (clock),
    .reset            (reset),
    .init_start       (init_start),
    .traffic_idle     (traffic_idle),
    .hold_traffic     (hold_traffic),
    .mc_ctrlupd_start (mc_ctrlupd_start),
    .mc_lp_en         (mc_lp_en),
    .mc_lp_data_only  (mc_lp_data_only),
    .mc_lp_wakeup     (mc_lp_wakeup),
    .lp_denied        (lp_denied),
    .ctrlupd_done     (ctrlupd_done),
    .dfi              (dfi)
  );

  // Mutual exclusion of the four handshakes, and silence while init runs.
  always @(negedge clock) begin : mon
    int n;
    if (!reset) begin
      n = int'(dfi.phyupd_ack) + int'(dfi.phymstr_ack) + int'(dfi.ctrlupd_req)
        + int'(dfi.lp_ctrl_req | dfi.lp_data_req);
      if (n > 1) excl_viol++;
      if (init_start && (n != 0)) excl_viol++;
    end
  end

  function automatic logic [19:0] all_outs();
    return {hold_traffic, lp_denied, ctrlupd_done, dfi.ctrlupd_req, dfi.phyupd_ack,
            dfi.phymstr_ack, dfi.lp_ctrl_req, dfi.lp_data_req, dfi.lp_ctrl_wakeup,
            dfi.lp_data_wakeup};
  endfunction

  function automatic logic sig(int which);
    case (which)
      0: return hold_traffic;
      1: return dfi.phyupd_ack;
      2: return dfi.phymstr_ack;
      3: return dfi.ctrlupd_req;
      default: return dfi.lp_data_req;
    endcase
  endfunction

  // Expected ctrlupd_req high time: ack window plus the cycle that sees ack low, clamped.
  function automatic int ctrlupd_len_model(int ack_cycles);
    int l;
    l = (ack_cycles > 0) ? ack_cycles + 1 : 1;
    if (l < TC_MIN) l = TC_MIN;
    if (l > TC_MAX) l = TC_MAX;
    return l;
  endfunction

  task automatic wait_sig(input int which, input logic val, input int budget, output bit ok);
    int cyc;
    cyc = 0;
    while ((sig(which) !== val) && (cyc < budget)) begin
      @(negedge clock);
      cyc++;
    end
    ok = (sig(which) === val);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    total++;
    if (all_outs() !== 20'd0) $display("FAIL reset_outs got=%h exp=0", all_outs());
    else passed++;
    reset = 1'b0;
    @(negedge clock);
    total++;
    if (hold_traffic !== 1'b0) $display("FAIL reset_idle_hold got=%b exp=0", hold_traffic);
    else passed++;
  endtask

  task automatic test_phyupd();
    bit early;
    traffic_idle   = 1'b0;
    dfi.phyupd_req = 1'b1;
    @(negedge clock);
    total++;
    if (hold_traffic !== 1'b1) $display("FAIL phyupd_hold got=%b exp=1", hold_traffic);
    else passed++;
    early = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (dfi.phyupd_ack !== 1'b0) early = 1'b1;
      @(negedge clock);
    end
    if (dfi.phyupd_ack !== 1'b0) early = 1'b1;
    total++;
    if (early !== 1'b0) $display("FAIL phyupd_ack_during_drain got=1 exp=0");
    else passed++;
    traffic_idle = 1'b1;
    @(negedge clock);
    total++;
    if (dfi.phyupd_ack !== 1'b1) $display("FAIL phyupd_ack_rise got=%b exp=1", dfi.phyupd_ack);
    else passed++;
    repeat (2) @(negedge clock);
    dfi.phyupd_req = 1'b0;
    @(negedge clock);
    total++;
    if ({dfi.phyupd_ack, hold_traffic} !== 2'b00)
      $display("FAIL phyupd_ack_fall got=%b exp=00", {dfi.phyupd_ack, hold_traffic});
    else passed++;
  endtask

  task automatic test_ctrlupd();
    int ack_cyc[3] = '{10, 0, 100};
    int len, e;
    bit ok;
    for (int i = 0; i < 3; i++) begin
      traffic_idle     = 1'b1;
      mc_ctrlupd_start = 1'b1;
      exp_q.push_back(ctrlupd_len_model(ack_cyc[i]));
      @(negedge clock);
      mc_ctrlupd_start = 1'b0;
      wait_sig(3, 1'b1, 10, ok);
      total++;
      if (ok !== 1'b1) $display("FAIL ctrlupd_req_timeout run=%0d got=0 exp=1", i);
      else passed++;
      len = 0;
      dfi.ctrlupd_ack = (ack_cyc[i] > 0);
      while ((dfi.ctrlupd_req === 1'b1) && (len < 64)) begin
        len++;
        if (len == ack_cyc[i] + 1) dfi.ctrlupd_ack = 1'b0;
        @(negedge clock);
      end
      dfi.ctrlupd_ack = 1'b0;
      total++;
      if (ctrlupd_done !== 1'b1) $display("FAIL ctrlupd_done_pulse run=%0d got=%b exp=1", i, ctrlupd_done);
      else passed++;
      e = exp_q.pop_front();
      total++;
      if (len !== e) $display("FAIL ctrlupd_req_len run=%0d got=%0d exp=%0d", i, len, e);
      else passed++;
      @(negedge clock);
      total++;
      if ({ctrlupd_done, hold_traffic} !== 2'b00)
        $display("FAIL ctrlupd_done_once run=%0d got=%b exp=00", i, {ctrlupd_done, hold_traffic});
      else passed++;
    end
  endtask

  task automatic test_lp_denied();
    int len, e;
    bit ok;
    mc_lp_data_only = 1'b0;
    mc_lp_wakeup    = 6'h2A;
    mc_lp_en        = 1'b1;
    exp_q.push_back(TLP);
    wait_sig(4, 1'b1, 10, ok);
    total++;
    if (ok !== 1'b1) $display("FAIL lp_req_timeout got=0 exp=1");
    else passed++;
    total++;
    if ({dfi.lp_ctrl_req, dfi.lp_ctrl_wakeup, dfi.lp_data_wakeup} !== {1'b1, 6'h2A, 6'h2A})
      $display("FAIL lp_req_wakeup got=%b/%h/%h exp=1/2a/2a", dfi.lp_ctrl_req,
               dfi.lp_ctrl_wakeup, dfi.lp_data_wakeup);
    else passed++;
    dfi.lp_data_ack = 1'b1;
    len = 0;
    while ((dfi.lp_data_req === 1'b1) && (len < 64)) begin
      len++;
      @(negedge clock);
    end
    mc_lp_en = 1'b0;
    e = exp_q.pop_front();
    total++;
    if (len !== e) $display("FAIL lp_req_len got=%0d exp=%0d", len, e);
    else passed++;
    total++;
    if ({lp_denied, dfi.lp_ctrl_req, hold_traffic} !== 3'b100)
      $display("FAIL lp_denied_pulse got=%b exp=100", {lp_denied, dfi.lp_ctrl_req, hold_traffic});
    else passed++;
    @(negedge clock);
    dfi.lp_data_ack = 1'b0;
    total++;
    if ({lp_denied, hold_traffic} !== 2'b00)
      $display("FAIL lp_denied_once got=%b exp=00", {lp_denied, hold_traffic});
    else passed++;
  endtask

  task automatic test_lp_data_only();
    bit ok;
    mc_lp_data_only = 1'b1;
    mc_lp_wakeup    = 6'h0F;
    mc_lp_en        = 1'b1;
    wait_sig(4, 1'b1, 10, ok);
    total++;
    if (ok !== 1'b1) $display("FAIL lp_do_req_timeout got=0 exp=1");
    else passed++;
    total++;
    if ({dfi.lp_ctrl_req, dfi.lp_ctrl_wakeup, dfi.lp_data_wakeup} !== {1'b0, 6'h00, 6'h0F})
      $display("FAIL lp_do_outputs got=%b/%h/%h exp=0/00/0f", dfi.lp_ctrl_req,
               dfi.lp_ctrl_wakeup, dfi.lp_data_wakeup);
    else passed++;
    dfi.lp_data_ack = 1'b1;
    repeat (12) @(negedge clock);
    total++;
    if ({dfi.lp_data_req, lp_denied} !== 2'b10)
      $display("FAIL lp_do_active got=%b exp=10", {dfi.lp_data_req, lp_denied});
    else passed++;
    mc_lp_en = 1'b0;
    @(negedge clock);
    total++;
    if ({dfi.lp_data_req, hold_traffic} !== 2'b01)
      $display("FAIL lp_do_exit got=%b exp=01", {dfi.lp_data_req, hold_traffic});
    else passed++;
    dfi.lp_data_ack = 1'b0;
    @(negedge clock);
    total++;
    if (hold_traffic !== 1'b0) $display("FAIL lp_do_release got=%b exp=0", hold_traffic);
    else passed++;
    mc_lp_data_only = 1'b0;
  endtask

  task automatic test_reset_lp_active();
    bit ok;
    mc_lp_wakeup = 6'h15;
    mc_lp_en     = 1'b1;
    wait_sig(4, 1'b1, 10, ok);
    dfi.lp_ctrl_ack = 1'b1;
    dfi.lp_data_ack = 1'b1;
    repeat (3) @(negedge clock);
    total++;
    if ({ok, dfi.lp_ctrl_req, dfi.lp_data_req} !== 3'b111)
      $display("FAIL lp_active_hold got=%b exp=111", {ok, dfi.lp_ctrl_req, dfi.lp_data_req});
    else passed++;
    reset = 1'b1;
    @(negedge clock);
    total++;
    if (all_outs() !== 20'd0) $display("FAIL reset_mid_lp got=%h exp=0", all_outs());
    else passed++;
    mc_lp_en        = 1'b0;
    dfi.lp_ctrl_ack = 1'b0;
    dfi.lp_data_ack = 1'b0;
    reset           = 1'b0;
    @(negedge clock);
    total++;
    if (hold_traffic !== 1'b0) $display("FAIL reset_mid_lp_idle got=%b exp=0", hold_traffic);
    else passed++;
  endtask

  task automatic test_phyupd_then_ctrlupd();
    int len, e;
    bit ok;
    traffic_idle     = 1'b1;
    dfi.phyupd_req   = 1'b1;
    mc_ctrlupd_start = 1'b1;
    exp_q.push_back(ctrlupd_len_model(0));
    @(negedge clock);
    mc_ctrlupd_start = 1'b0;
    wait_sig(1, 1'b1, 10, ok);
    total++;
    if ({ok, dfi.ctrlupd_req} !== 2'b10)
      $display("FAIL both_phyupd_first got=%b exp=10", {ok, dfi.ctrlupd_req});
    else passed++;
    repeat (3) @(negedge clock);
    dfi.phyupd_req = 1'b0;
    wait_sig(3, 1'b1, 10, ok);
    total++;
    if ({ok, dfi.phyupd_ack} !== 2'b10)
      $display("FAIL both_ctrlupd_after got=%b exp=10", {ok, dfi.phyupd_ack});
    else passed++;
    len = 0;
    while ((dfi.ctrlupd_req === 1'b1) && (len < 64)) begin
      len++;
      @(negedge clock);
    end
    e = exp_q.pop_front();
    total++;
    if (len !== e) $display("FAIL both_ctrlupd_len got=%0d exp=%0d", len, e);
    else passed++;
    total++;
    if (excl_viol !== 0) $display("FAIL exclusion_both got=%0d exp=0", excl_viol);
    else passed++;
  endtask

  task automatic test_init_block();
    bit leak, ok;
    int len, e;
    init_start       = 1'b1;
    traffic_idle     = 1'b1;
    dfi.phyupd_req   = 1'b1;
    dfi.phymstr_req  = 1'b1;
    mc_ctrlupd_start = 1'b1;
    exp_q.push_back(ctrlupd_len_model(0));
    @(negedge clock);
    mc_ctrlupd_start = 1'b0;
    leak = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (all_outs() !== 20'd0) leak = 1'b1;
    end
    total++;
    if (leak !== 1'b0) $display("FAIL init_blocks got=1 exp=0");
    else passed++;
    init_start = 1'b0;
    @(negedge clock);
    total++;
    if (hold_traffic !== 1'b1) $display("FAIL init_release_hold got=%b exp=1", hold_traffic);
    else passed++;
    wait_sig(1, 1'b1, 10, ok);
    total++;
    if ({ok, dfi.phymstr_ack} !== 2'b10)
      $display("FAIL init_phyupd_wins got=%b exp=10", {ok, dfi.phymstr_ack});
    else passed++;
    dfi.phyupd_req = 1'b0;
    wait_sig(2, 1'b1, 10, ok);
    total++;
    if (ok !== 1'b1) $display("FAIL init_phymstr_timeout got=0 exp=1");
    else passed++;
    dfi.phymstr_req = 1'b0;
    wait_sig(3, 1'b1, 10, ok);
    len = 0;
    while ((dfi.ctrlupd_req === 1'b1) && (len < 64)) begin
      len++;
      @(negedge clock);
    end
    e = exp_q.pop_front();
    total++;
    if ({ok, len} !== {1'b1, e}) $display("FAIL init_ctrlupd_len got=%b/%0d exp=1/%0d", ok, len, e);
    else passed++;
    total++;
    if (excl_viol !== 0) $display("FAIL exclusion_all got=%0d exp=0", excl_viol);
    else passed++;
  endtask

  initial begin
    dfi.ctrlupd_ack = 1'b0;
    dfi.phyupd_req  = 1'b0;
    dfi.phymstr_req = 1'b0;
    dfi.lp_ctrl_ack = 1'b0;
    dfi.lp_data_ack = 1'b0;
    test_reset();
    test_phyupd();
    test_ctrlupd();
    test_lp_denied();
    test_lp_data_only();
    test_reset_lp_active();
    test_phyupd_then_ctrlupd();
    test_init_block();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench timeout");
  end

endmodule
